pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage RV32I pipeline. It takes instruction- and data-memory handshakes, load-use hazard operands and the EX-stage mispredict flag, and drives the `load` and `flush` inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. A 3-state FSM tracks which memory access has completed while the other is outstanding. Three performance counters record stall cycles, bubbles and flushes.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/load_use_detect.sv | 13 +
 rtl/pipeline_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: control word carried down the pipe and the
// stall/flush sequencer state.
package rv32i_types;

  typedef enum logic [1:0] {
    PC_BOTH  = 2'd0,
    PC_IDONE = 2'd1,
    PC_DDONE = 2'd2
  } pipeline_ctrl_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } rv32i_control_word;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in ID/EX and the IF/ID
// source operands; x0 never creates a dependency.
module load_use_detect (
  input  logic       memread,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  assign hazard = memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: freezes on outstanding
// memory accesses, inserts load-use bubbles and squashes on mispredict.
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             mem_req,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             br_mispredict,
  output logic             imem_read,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipeline_ctrl_state_t state_reg, state_next;
  logic hazard, i_ok, d_ok, advance, do_bubble, do_flush;

  load_use_detect u_load_use (
    .memread (id_ex_memread),
    .rd      (id_ex_rd),
    .rs1     (if_id_rs1),
    .rs2     (if_id_rs2),
    .hazard  (hazard)
  );

  // A done state stands in for the response that already arrived.
  assign i_ok      = imem_resp || (state_reg == PC_IDONE);
  assign d_ok      = !mem_req || dmem_resp || (state_reg == PC_DDONE);
  assign advance   = !rst && i_ok && d_ok;
  assign imem_read = !rst && (state_reg != PC_IDONE);
  assign do_flush  = advance && br_mispredict;
  assign do_bubble = advance && hazard && !br_mispredict;

  always_comb begin
    state_next = state_reg;
    if (advance) begin
      state_next = PC_BOTH;
    end else if (state_reg == PC_BOTH) begin
      if (imem_resp)
        state_next = PC_IDONE;
      else if (mem_req && dmem_resp)
        state_next = PC_DDONE;
    end
  end

  always_comb begin
    load_pc     = advance && !do_bubble;
    load_if_id  = advance && !do_bubble;
    load_id_ex  = advance;
    load_ex_mem = advance;
    load_mem_wb = advance;
    flush_if_id = do_flush;
    flush_id_ex = do_flush || do_bubble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= PC_BOTH;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      state_reg <= state_next;
      if (!advance)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_bubble)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (do_flush)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a narrow-counter copy shares the inputs
// to exercise counter wrap.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_resp, dmem_resp, mem_req, id_ex_memread, br_mispredict;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;

  logic        w_imem_read, w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb;
  logic        w_flush_if_id, w_flush_id_ex;
  logic [31:0] w_stall, w_bubble, w_flush;
  logic        n_imem_read, n_load_pc, n_load_if_id, n_load_id_ex, n_load_ex_mem, n_load_mem_wb;
  logic        n_flush_if_id, n_flush_id_ex;
  logic [3:0]  n_stall, n_bubble, n_flush;
  logic [7:0]  ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp), .mem_req(mem_req),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .br_mispredict(br_mispredict), .imem_read(w_imem_read), .load_pc(w_load_pc),
    .load_if_id(w_load_if_id), .load_id_ex(w_load_id_ex), .load_ex_mem(w_load_ex_mem),
    .load_mem_wb(w_load_mem_wb), .flush_if_id(w_flush_if_id), .flush_id_ex(w_flush_id_ex),
    .stall_cnt(w_stall), .bubble_cnt(w_bubble), .flush_cnt(w_flush)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp), .mem_req(mem_req),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .br_mispredict(br_mispredict), .imem_read(n_imem_read), .load_pc(n_load_pc),
    .load_if_id(n_load_if_id), .load_id_ex(n_load_id_ex), .load_ex_mem(n_load_ex_mem),
    .load_mem_wb(n_load_mem_wb), .flush_if_id(n_flush_if_id), .flush_id_ex(n_flush_id_ex),
    .stall_cnt(n_stall), .bubble_cnt(n_bubble), .flush_cnt(n_flush)
  );

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, imem_read}
  assign ctl = {w_load_pc, w_load_if_id, w_load_id_ex, w_load_ex_mem, w_load_mem_wb,
                w_flush_if_id, w_flush_id_ex, w_imem_read};

  localparam logic [7:0] CTL_FREEZE_F = 8'b0000_0001;
  localparam logic [7:0] CTL_ZERO     = 8'b0000_0000;
  localparam logic [7:0] CTL_RUN      = 8'b1111_1001;
  localparam logic [7:0] CTL_RUN_NOF  = 8'b1111_1000;
  localparam logic [7:0] CTL_BUBBLE   = 8'b0011_1011;
  localparam logic [7:0] CTL_FLUSH    = 8'b1111_1111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s got=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_resp = 0; dmem_resp = 0; mem_req = 0;
    id_ex_memread = 0; br_mispredict = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    tick(); tick();
    chk("rst_ctl", ctl, CTL_ZERO);
    chk("rst_stall", w_stall, 0);
    rst = 1'b0;

    // Plain advance
    imem_resp = 1;
    for (int i = 0; i < 3; i++) begin
      #3 chk("plain_ctl", ctl, CTL_RUN);
      tick();
    end
    chk("plain_stall", w_stall, 0);

    // Split completion: imem at cycle 2, dmem at cycle 5
    mem_req = 1; imem_resp = 0;
    #3 chk("split_c1", ctl, CTL_FREEZE_F); tick();
    imem_resp = 1;
    #3 chk("split_c2", ctl, CTL_FREEZE_F); tick();
    imem_resp = 0;
    #3 chk("split_c3", ctl, CTL_ZERO); tick();
    imem_resp = 1;
    #3 chk("split_c4_rep", ctl, CTL_ZERO); tick();
    imem_resp = 0; dmem_resp = 1;
    #3 chk("split_c5_adv", ctl, CTL_RUN_NOF); tick();
    chk("split_stall", w_stall, 4);
    dmem_resp = 0; mem_req = 0; imem_resp = 1;
    #3 chk("split_back", ctl, CTL_RUN); tick();

    // Mirror: dmem first
    mem_req = 1; dmem_resp = 1; imem_resp = 0;
    #3 chk("mir_c1", ctl, CTL_FREEZE_F); tick();
    #3 chk("mir_c2_rep", ctl, CTL_FREEZE_F); tick();
    dmem_resp = 0; imem_resp = 1;
    #3 chk("mir_adv", ctl, CTL_RUN); tick();
    chk("mir_stall", w_stall, 6);
    mem_req = 0;

    // Load-use
    id_ex_memread = 1; id_ex_rd = 5; if_id_rs1 = 3; if_id_rs2 = 5;
    #3 chk("lu_rs2", ctl, CTL_BUBBLE); tick();
    chk("lu_bub1", w_bubble, 1);
    id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    #3 chk("lu_rd0", ctl, CTL_RUN); tick();
    chk("lu_bub_rd0", w_bubble, 1);
    id_ex_rd = 9; if_id_rs1 = 9;
    #3 chk("lu_rs1", ctl, CTL_BUBBLE); tick();
    chk("lu_bub2", w_bubble, 2);

    // Mispredict with hazard present
    id_ex_rd = 5; if_id_rs1 = 0; if_id_rs2 = 5; br_mispredict = 1;
    #3 chk("mp_ctl", ctl, CTL_FLUSH); tick();
    chk("mp_flush1", w_flush, 1);
    chk("mp_bub", w_bubble, 2);
    id_ex_memread = 0; imem_resp = 0;
    #3 chk("mp_stall_ctl", ctl, CTL_FREEZE_F); tick();
    chk("mp_stall_fc", w_flush, 1);
    imem_resp = 1;
    #3 chk("mp_adv_ctl", ctl, CTL_FLUSH); tick();
    chk("mp_flush2", w_flush, 2);
    chk("mp_stall_cnt", w_stall, 7);
    br_mispredict = 0;

    // Async reset mid-stall in PC_IDONE
    mem_req = 1; imem_resp = 1; dmem_resp = 0;
    #3 chk("ar_pre", ctl, CTL_FREEZE_F); tick();
    imem_resp = 0;
    #3 chk("ar_idone", ctl, CTL_ZERO);
    chk("ar_stall8", w_stall, 8);
    #2 rst = 1'b1; imem_resp = 1; dmem_resp = 1;
    #1 chk("ar_ctl", ctl, CTL_ZERO);
    chk("ar_stall", w_stall, 0);
    chk("ar_bubble", w_bubble, 0);
    chk("ar_flush", w_flush, 0);
    tick(); tick();
    rst = 1'b0; imem_resp = 0; dmem_resp = 0; mem_req = 0;
    #3 chk("ar_both", ctl, CTL_FREEZE_F); tick();
    chk("ar_stall1", w_stall, 1);

    // Wrap: 17 stall cycles on a 4-bit counter
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    chk("wrap_wide", w_stall, 17);
    chk("wrap_narrow", {28'd0, n_stall}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
